// File: rtl/weight_loader_pkg.sv
// weight_loader_pkg
// Shared definitions for the weight/bias loader and the parameter memories
// it feeds: frame opcodes, FSM state encoding and default memory geometry.
// No ports (package).

package weight_loader_pkg;

    // Frame opcodes (first byte of every frame)
    localparam logic [7:0] OP_WEIGHT = 8'hA5;
    localparam logic [7:0] OP_BIAS   = 8'h5B;

    // Loader FSM state encoding
    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_HDR_ALO = 4'd1;
    localparam logic [3:0] ST_HDR_AHI = 4'd2;
    localparam logic [3:0] ST_HDR_CLO = 4'd3;
    localparam logic [3:0] ST_HDR_CHI = 4'd4;
    localparam logic [3:0] ST_PAYLOAD = 4'd5;
    localparam logic [3:0] ST_CKSUM   = 4'd6;
    localparam logic [3:0] ST_DONE    = 4'd7;
    localparam logic [3:0] ST_ERR     = 4'd8;

    // Geometry shared with the weight (Q1.7) and bias (Q8.8) memories
    localparam int DEF_WEIGHT_WIDTH = 8;
    localparam int DEF_W_DEPTH      = 2048;
    localparam int DEF_W_ADDR_WIDTH = 11;
    localparam int DEF_BIAS_WIDTH   = 16;
    localparam int DEF_B_DEPTH      = 64;
    localparam int DEF_B_ADDR_WIDTH = 6;

endpackage

// File: rtl/weight_loader_cksum.sv
// weight_loader_cksum
// 8-bit mod-256 running sum of frame bytes.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the sum (loads data instead when add is also set)
//   add        : accumulate data this cycle
//   data       : byte to accumulate
//   zero       : the sum including the current data byte is zero

module weight_loader_cksum (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       add,
    input  logic [7:0] data,
    output logic       zero
);

    logic [7:0] sum;
    logic [7:0] sum_plus;

    assign sum_plus = sum + data;

    // zero looks ahead by one byte so the loader can decide DONE/ERR on the
    // same edge that accepts the checksum byte.
    assign zero = (sum_plus == 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= 8'd0;
        end else if (clear) begin
            sum <= add ? data : 8'd0;
        end else if (add) begin
            sum <= sum_plus;
        end
    end

endmodule

// File: rtl/weight_loader.sv
// weight_loader
// Host-side writer for the weight (Q1.7) and bias (Q8.8) RAMs. Decodes a
// framed byte stream OP, ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, payload, CKSUM
// and writes the payload entries, then checks the mod-256 frame sum.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   s_data, s_valid, s_ready        : byte stream in (valid/ready)
//   w_wr_en, w_wr_addr, w_wr_data   : weight RAM write port
//   b_wr_en, b_wr_addr, b_wr_data   : bias RAM write port
//   busy                            : frame in progress
//   done / err                      : one-cycle frame good / frame bad pulses
// Optional build macro: WEIGHT_LOADER_TIMEOUT_EN adds an inter-byte timeout
// of TIMEOUT_CYCLES idle cycles while busy.

module weight_loader
    import weight_loader_pkg::*;
#(
    parameter int WEIGHT_WIDTH   = DEF_WEIGHT_WIDTH,
    parameter int W_DEPTH        = DEF_W_DEPTH,
    parameter int W_ADDR_WIDTH   = DEF_W_ADDR_WIDTH,
    parameter int BIAS_WIDTH     = DEF_BIAS_WIDTH,
    parameter int B_DEPTH        = DEF_B_DEPTH,
    parameter int B_ADDR_WIDTH   = DEF_B_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic                    w_wr_en,
    output logic [W_ADDR_WIDTH-1:0] w_wr_addr,
    output logic [WEIGHT_WIDTH-1:0] w_wr_data,
    output logic                    b_wr_en,
    output logic [B_ADDR_WIDTH-1:0] b_wr_addr,
    output logic [BIAS_WIDTH-1:0]   b_wr_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    logic [3:0]  state;
    logic        is_bias;
    logic [15:0] addr;
    logic [15:0] count;
    logic [7:0]  lo_q;
    logic        lo_held;

    logic        accept;
    logic        is_op;
    logic [15:0] hdr_count;
    logic [16:0] range_end;
    logic [16:0] depth;
    logic        high_bits_set;
    logic        range_bad;
    logic        cks_clear;
    logic        cks_add;
    logic        cks_zero;
    logic        timeout_hit;

    assign s_ready = (state != ST_DONE) && (state != ST_ERR);
    assign accept  = s_valid && s_ready;
    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_DONE);
    assign err     = (state == ST_ERR);
    assign is_op   = (s_data == OP_WEIGHT) || (s_data == OP_BIAS);

    // Header range check, evaluated with the CNT_HI byte still on s_data.
    // A 17-bit sum avoids wrap; base bits above the RAM address width are
    // rejected separately so base == depth with count == 0 also fails.
    always_comb begin
        hdr_count     = {s_data, count[7:0]};
        range_end     = {1'b0, addr} + {1'b0, hdr_count};
        depth         = is_bias ? 17'(B_DEPTH) : 17'(W_DEPTH);
        high_bits_set = is_bias ? ((addr >> B_ADDR_WIDTH) != 16'd0)
                                : ((addr >> W_ADDR_WIDTH) != 16'd0);
        range_bad     = (range_end > depth) || high_bits_set;
    end

    // The sum restarts in IDLE and is seeded by the opcode byte; dropped
    // garbage bytes in IDLE never reach it.
    assign cks_clear = (state == ST_IDLE);
    assign cks_add   = accept && ((state != ST_IDLE) || is_op);

    weight_loader_cksum u_cksum (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cks_clear),
        .add   (cks_add),
        .data  (s_data),
        .zero  (cks_zero)
    );

`ifdef WEIGHT_LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_cnt;
    logic          waiting;

    assign waiting     = busy && (state != ST_DONE) && (state != ST_ERR);
    assign timeout_hit = waiting && !accept && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (!waiting || accept) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            is_bias   <= 1'b0;
            addr      <= 16'd0;
            count     <= 16'd0;
            lo_q      <= 8'd0;
            lo_held   <= 1'b0;
            w_wr_en   <= 1'b0;
            w_wr_addr <= '0;
            w_wr_data <= '0;
            b_wr_en   <= 1'b0;
            b_wr_addr <= '0;
            b_wr_data <= '0;
        end else begin
            w_wr_en <= 1'b0;
            b_wr_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept && is_op) begin
                        is_bias <= (s_data == OP_BIAS);
                        lo_held <= 1'b0;
                        state   <= ST_HDR_ALO;
                    end
                end
                ST_HDR_ALO: begin
                    if (accept) begin
                        addr[7:0] <= s_data;
                        state     <= ST_HDR_AHI;
                    end
                end
                ST_HDR_AHI: begin
                    if (accept) begin
                        addr[15:8] <= s_data;
                        state      <= ST_HDR_CLO;
                    end
                end
                ST_HDR_CLO: begin
                    if (accept) begin
                        count[7:0] <= s_data;
                        state      <= ST_HDR_CHI;
                    end
                end
                ST_HDR_CHI: begin
                    if (accept) begin
                        count[15:8] <= s_data;
                        if (range_bad) begin
                            state <= ST_ERR;
                        end else if (hdr_count == 16'd0) begin
                            state <= ST_CKSUM;
                        end else begin
                            state <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (accept) begin
                        if (!is_bias) begin
                            w_wr_en   <= 1'b1;
                            w_wr_addr <= addr[W_ADDR_WIDTH-1:0];
                            w_wr_data <= WEIGHT_WIDTH'(s_data);
                            addr      <= addr + 16'd1;
                            count     <= count - 16'd1;
                            if (count == 16'd1) begin
                                state <= ST_CKSUM;
                            end
                        end else if (!lo_held) begin
                            lo_q    <= s_data;
                            lo_held <= 1'b1;
                        end else begin
                            b_wr_en   <= 1'b1;
                            b_wr_addr <= addr[B_ADDR_WIDTH-1:0];
                            b_wr_data <= BIAS_WIDTH'({s_data, lo_q});
                            lo_held   <= 1'b0;
                            addr      <= addr + 16'd1;
                            count     <= count - 16'd1;
                            if (count == 16'd1) begin
                                state <= ST_CKSUM;
                            end
                        end
                    end
                end
                ST_CKSUM: begin
                    if (accept) begin
                        state <= cks_zero ? ST_DONE : ST_ERR;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            // Timeout overrides whatever the idle state would have done.
            if (timeout_hit) begin
                state <= ST_ERR;
            end
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader
// Self-checking bench for weight_loader: directed frames from the test plan
// plus randomized frames with random s_valid stalls, checked against a
// frame-level reference model. Define WEIGHT_LOADER_TIMEOUT_EN to also
// exercise the inter-byte timeout (TIMEOUT_CYCLES = 16 here).

module tb_weight_loader;

    localparam int TO_CYCLES = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        w_wr_en;
    logic [10:0] w_wr_addr;
    logic [7:0]  w_wr_data;
    logic        b_wr_en;
    logic [5:0]  b_wr_addr;
    logic [15:0] b_wr_data;
    logic        busy;
    logic        done;
    logic        err;

    weight_loader #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .w_wr_en   (w_wr_en),
        .w_wr_addr (w_wr_addr),
        .w_wr_data (w_wr_data),
        .b_wr_en   (b_wr_en),
        .b_wr_addr (b_wr_addr),
        .b_wr_data (b_wr_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        bias;
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t  obsQ[$];
    wr_t  expQ[$];
    int   doneCnt = 0;
    int   errCnt = 0;
    logic readyInPulse = 1'b0;
    int   total = 0;
    int   bad = 0;

    // Observe the DUT on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (w_wr_en) obsQ.push_back({1'b0, 16'(w_wr_addr), 16'(w_wr_data)});
        if (b_wr_en) obsQ.push_back({1'b1, 16'(b_wr_addr), b_wr_data});
        if (done) doneCnt++;
        if (err) errCnt++;
        if ((done || err) && s_ready) readyInPulse = 1'b1;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Frame-level reference: find the opcode, apply the header range rule,
    // list the writes the payload implies and decide good/bad from the
    // mod-256 sum of the whole frame.
    task automatic modelFrame(input logic [7:0] fr[$], output int eDone, output int eErr);
        int i;
        int j;
        int base;
        int cnt;
        int depth;
        int abits;
        int sum;
        int data;
        logic bias;
        wr_t w;
        expQ.delete();
        eDone = 0;
        eErr = 0;
        i = 0;
        while (i < fr.size() && fr[i] != 8'hA5 && fr[i] != 8'h5B) i++;
        if (i + 4 >= fr.size()) return;
        bias  = (fr[i] == 8'h5B);
        base  = int'(fr[i+2]) * 256 + int'(fr[i+1]);
        cnt   = int'(fr[i+4]) * 256 + int'(fr[i+3]);
        depth = bias ? 64 : 2048;
        abits = bias ? 6 : 11;
        if (base + cnt > depth || base >= (1 << abits)) begin
            eErr = 1;
            return;
        end
        j = i + 5;
        for (int e = 0; e < cnt; e++) begin
            if (bias) begin
                data = int'(fr[j+1]) * 256 + int'(fr[j]);
                j += 2;
            end else begin
                data = int'(fr[j]);
                j += 1;
            end
            w.bias = bias;
            w.addr = 16'(base + e);
            w.data = 16'(data);
            expQ.push_back(w);
        end
        sum = 0;
        for (int k = i; k <= j && k < fr.size(); k++) sum += int'(fr[k]);
        if (sum % 256 == 0) eDone = 1;
        else eErr = 1;
    endtask

    // Present one byte after a random number of idle cycles; bounded wait
    task automatic sendByte(input logic [7:0] b, input int maxStall);
        logic r;
        int   n;
        repeat ($urandom_range(maxStall, 0)) @(posedge clk);
        #1;
        s_valid = 1'b1;
        s_data  = b;
        r = 1'b0;
        n = 0;
        while (!r && n < 50) begin
            @(negedge clk);
            r = s_ready;
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("handshake", {63'd0, r}, 64'd1);
        s_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] fr[$], input int maxStall, input string tag);
        int eDone;
        int eErr;
        int n;
        modelFrame(fr, eDone, eErr);
        obsQ.delete();
        doneCnt = 0;
        errCnt = 0;
        readyInPulse = 1'b0;
        foreach (fr[k]) sendByte(fr[k], maxStall);
        repeat (4) @(posedge clk);
        #1;
        checkOutput({tag, ".nwr"}, 64'(obsQ.size()), 64'(expQ.size()));
        n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
        for (int k = 0; k < n; k++) checkOutput({tag, ".wr"}, 64'(obsQ[k]), 64'(expQ[k]));
        checkOutput({tag, ".done"}, 64'(doneCnt), 64'(eDone));
        checkOutput({tag, ".err"}, 64'(errCnt), 64'(eErr));
        checkOutput({tag, ".busy"}, {63'd0, busy}, 64'd0);
        checkOutput({tag, ".rdyPulse"}, {63'd0, readyInPulse}, 64'd0);
    endtask

    task automatic genFrame(output logic [7:0] fr[$]);
        logic bias;
        int   depth;
        int   cnt;
        int   base;
        int   sum;
        logic [7:0] b;
        fr.delete();
        bias  = $urandom_range(1, 0) == 1;
        depth = bias ? 64 : 2048;
        if ($urandom_range(5, 0) == 0) begin
            cnt  = $urandom_range(4, 1);
            base = depth - cnt + 1 + $urandom_range(2, 0);
            fr.push_back(bias ? 8'h5B : 8'hA5);
            fr.push_back(8'(base));
            fr.push_back(8'(base >> 8));
            fr.push_back(8'(cnt));
            fr.push_back(8'(cnt >> 8));
            return;
        end
        if ($urandom_range(3, 0) == 0) fr.push_back(8'($urandom_range(255, 0) & 8'h0F));
        cnt  = $urandom_range(5, 0);
        base = $urandom_range(depth - cnt, 0);
        fr.push_back(bias ? 8'h5B : 8'hA5);
        sum = bias ? 8'h5B : 8'hA5;
        fr.push_back(8'(base));
        fr.push_back(8'(base >> 8));
        fr.push_back(8'(cnt));
        fr.push_back(8'(cnt >> 8));
        sum += (base & 255) + (base >> 8) + cnt;
        for (int e = 0; e < (bias ? 2 * cnt : cnt); e++) begin
            b = 8'($urandom_range(255, 0));
            fr.push_back(b);
            sum += int'(b);
        end
        b = 8'((256 - (sum % 256)) % 256);
        if ($urandom_range(3, 0) == 0) b = b + 8'd1;
        fr.push_back(b);
    endtask

    initial begin
        logic [7:0] f[$];
        logic       busyBefore;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.busy", {63'd0, busy}, 64'd0);
        checkOutput("rst.done", {63'd0, done}, 64'd0);
        checkOutput("rst.err", {63'd0, err}, 64'd0);
        checkOutput("rst.wen", {62'd0, w_wr_en, b_wr_en}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        f = '{8'hA5, 8'h10, 8'h00, 8'h02, 8'h00, 8'h20, 8'h40, 8'hE9};
        applyStimulus(f, 0, "wframe");
        f = '{8'h5B, 8'h20, 8'h00, 8'h01, 8'h00, 8'h08, 8'h00, 8'h7C};
        applyStimulus(f, 0, "bframe");
        f = '{8'hA5, 8'hFF, 8'h07, 8'h02, 8'h00};
        applyStimulus(f, 0, "range");
        f = '{8'hA5, 8'h10, 8'h00, 8'h02, 8'h00, 8'h20, 8'h40, 8'hE9};
        applyStimulus(f, 0, "afterRange");
        f = '{8'hA5, 8'h10, 8'h00, 8'h02, 8'h00, 8'h20, 8'h40, 8'hE8};
        applyStimulus(f, 0, "badCksum");
        f = '{8'h33, 8'h5B, 8'h3E, 8'h00, 8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h00};
        f[10] = 8'(256 - ((32'h5B + 32'h3E + 32'h02 + 32'h34 + 32'h12 + 32'hCD + 32'hAB) % 256));
        applyStimulus(f, 3, "garbage");
        f = '{8'hA5, 8'hFF, 8'h07, 8'h00, 8'h00, 8'h5C};
        applyStimulus(f, 2, "zeroCnt");

        // Asynchronous reset in the middle of a header
        sendByte(8'hA5, 0);
        sendByte(8'h10, 0);
        sendByte(8'h00, 0);
        busyBefore = busy;
        checkOutput("midRst.busyBefore", {63'd0, busyBefore}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midRst.busy", {63'd0, busy}, 64'd0);
        checkOutput("midRst.pulses", {62'd0, done, err}, 64'd0);
        checkOutput("midRst.wen", {62'd0, w_wr_en, b_wr_en}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        f = '{8'hA5, 8'h10, 8'h00, 8'h02, 8'h00, 8'h20, 8'h40, 8'hE9};
        applyStimulus(f, 1, "afterRst");

        for (int r = 0; r < 12; r++) begin
            genFrame(f);
            applyStimulus(f, 3, "rand");
        end

`ifdef WEIGHT_LOADER_TIMEOUT_EN
        begin
            int waitCnt;
            obsQ.delete();
            doneCnt = 0;
            errCnt = 0;
            f = '{8'hA5, 8'h00, 8'h00, 8'h04, 8'h00, 8'h11};
            foreach (f[k]) sendByte(f[k], 0);
            waitCnt = 0;
            while (errCnt == 0 && waitCnt < 40) begin
                @(negedge clk);
                waitCnt++;
            end
            checkOutput("timeout.err", 64'(errCnt), 64'd1);
            checkOutput("timeout.window", {63'd0, waitCnt >= TO_CYCLES && waitCnt <= TO_CYCLES + 2}, 64'd1);
            @(posedge clk);
            #1;
            checkOutput("timeout.busy", {63'd0, busy}, 64'd0);
            checkOutput("timeout.nwr", 64'(obsQ.size()), 64'd1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
Host-side writer for the weight and bias memories, the write counterpart of the read-only weight/bias stores.
- Accepts a framed byte stream over a valid/ready interface.
- Decodes a header (target, base address, entry count) and writes payload entries into the 8-bit Q1.7 weight RAM or the 16-bit Q8.8 bias RAM.
- Validates a trailing checksum and reports done/error per frame.
- Sits between the host link (UART/SPI bridge) and the generator/discriminator parameter memories.

Parameters:
- WEIGHT_WIDTH, 8, weight word width (Q1.7)
- W_DEPTH, 2048, weight RAM entries
- W_ADDR_WIDTH, 11, weight RAM address width
- BIAS_WIDTH, 16, bias word width (Q8.8)
- B_DEPTH, 64, bias RAM entries
- B_ADDR_WIDTH, 6, bias RAM address width
- TIMEOUT_CYCLES, 65535, inter-byte timeout; used only with the optional feature

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_data  in  8  stream byte
- s_valid  in  1  byte valid
- s_ready  out  1  loader can accept a byte
- w_wr_en  out  1  weight RAM write strobe
- w_wr_addr  out  W_ADDR_WIDTH  weight RAM address
- w_wr_data  out  WEIGHT_WIDTH  weight RAM data
- b_wr_en  out  1  bias RAM write strobe
- b_wr_addr  out  B_ADDR_WIDTH  bias RAM address
- b_wr_data  out  BIAS_WIDTH  bias RAM data
- busy  out  1  a frame is in progress (state not IDLE)
- done  out  1  one-cycle pulse: frame complete, checksum good
- err  out  1  one-cycle pulse: frame aborted or checksum bad

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n). All outputs, counters and the checksum clear to 0; state is IDLE.
- Byte transfer: a byte is accepted when s_valid && s_ready. s_ready = 1 in IDLE, HDR_* and PAYLOAD, CKSUM states; 0 in DONE and ERR.
- Frame format: OP, ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, payload, CKSUM.
  - OP 0xA5 = weights, 1 byte per entry.
  - OP 0x5B = biases, 2 bytes per entry, low byte first.
- FSM: IDLE -> HDR_ALO -> HDR_AHI -> HDR_CLO -> HDR_CHI -> PAYLOAD -> CKSUM -> DONE | ERR -> IDLE.
  - IDLE: an accepted byte other than 0xA5/0x5B is silently dropped; no err.
  - HDR_CHI: on acceptance, range-check base + count against W_DEPTH or B_DEPTH (17-bit compare). Exceeding the depth, or nonzero address bits above the address width -> ERR. count == 0 -> CKSUM directly.
  - PAYLOAD: weights: each accepted byte registers w_wr_en=1 with the current address and data on the next edge, then address increments. Biases: the low byte is held; on the high byte, b_wr_en=1 next cycle with {hi,lo}. Entry counter decrements per entry; the last entry -> CKSUM.
  - CKSUM: the checksum accumulator is the mod-256 sum of every accepted byte including OP. After adding the checksum byte, sum == 0 -> DONE, else ERR.
  - DONE and ERR each last one cycle, pulse done or err respectively, then return to IDLE.
- Write strobes are single-cycle; write latency is 1 cycle after acceptance of the completing byte. Write strobes are never asserted outside PAYLOAD writes.
- Payload writes are committed as they arrive. A checksum failure does not roll back written data; the host reloads the frame.
- Address wrap cannot occur, because the range check at HDR_CHI guarantees base + count ≤ depth.
- Reset mid-frame: the frame is discarded with no err pulse, and any pending write strobe is dropped.
- s_valid held low: the FSM stalls in its current state indefinitely, unless the optional feature is enabled.

Optional Feature:
- Macro: WEIGHT_LOADER_TIMEOUT_EN.
- Enabled: a counter of idle cycles (no accepted byte) runs while busy. Reaching TIMEOUT_CYCLES -> ERR (err pulse) -> IDLE. The counter clears on every accepted byte and in IDLE.
- Disabled: no counter is built; the FSM waits forever.

Decomposition:
- Shared package: opcode constants (OP_WEIGHT=8'hA5, OP_BIAS=8'h5B), the FSM state encoding, and the default depths/widths shared with the weight and bias memories.
- Sub-module: weight_loader_cksum, an 8-bit mod-256 accumulator with clear/add/zero-flag outputs.

Test Plan:
- Weight frame A5 10 00 02 00 20 40 E9 -> weight[0x010]=0x20 and weight[0x011]=0x40 on consecutive strobes; done pulses once; err stays 0.
- Bias frame 5B 20 00 01 00 08 00 7C -> one b_wr_en with addr 32, data 0x0008; done pulses.
- Range error A5 FF 07 02 00 (0x7FF+2 > 2048) -> err pulse after CNT_HI; no write strobes; the next valid frame loads normally.
- Bad checksum: the weight frame above with last byte E8 -> both writes occur; err pulses; done stays 0.
- Garbage byte 0x33 in IDLE, then a valid frame with s_valid toggled randomly -> 0x33 is ignored; writes and done are correct regardless of stalls.
- Reset asserted after the ADDR_HI byte -> all outputs 0 immediately (asynchronously); a subsequent full frame completes with done.
- With WEIGHT_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=16: stop mid-payload for 16 cycles -> err pulse; busy falls.
